// File: rtl/fetch_decode_stage_if.sv
// Instruction-memory request/response bus between the fetch stage (master)
// and instruction memory (slave).
interface fetch_decode_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_decode_stage.sv
// RV32I fetch stage: PC register, variable-latency imem fetch FSM and IF/ID register.
// Optional FETCH_PERF_EN adds perf_fetched / perf_bubbles counters.

module fetch_decode_stage_checker #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input logic        clk,
  input logic        reset,
  input logic [1:0]  state,
  input logic        req,
  input logic        ack,
  input logic [31:0] addr,
  input logic [31:0] pcf,
  input logic        fetch_busy,
  input logic        valid_d,
  input logic [31:0] instr_d
);
  a_state_legal: assert property (@(posedge clk) disable iff (reset) state != 2'd3);
  a_addr_is_pc:  assert property (@(posedge clk) disable iff (reset) addr == pcf);
  a_busy_def:    assert property (@(posedge clk) disable iff (reset) fetch_busy == (req & ~ack));
  a_bubble_nop:  assert property (@(posedge clk) disable iff (reset) !valid_d |-> instr_d == NOP_INSTR);
endmodule

module fetch_decode_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        StallF,
  input  logic                        StallD,
  input  logic                        FlushD,
  input  logic                        PCSrcE,
  input  logic [31:0]                 PCTargetE,
  fetch_decode_stage_if.master        bus,
  output logic [31:0]                 PCF,
  output logic [31:0]                 InstrD,
  output logic [31:0]                 PCD,
  output logic [31:0]                 PCPlus4D,
  output logic                        ValidD,
  output logic                        FetchBusy
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]                 perf_fetched,
  output logic [31:0]                 perf_bubbles
`endif
);

  typedef enum logic [1:0] {
    FETCH    = 2'd0,
    BUFFERED = 2'd1,
    DROP     = 2'd2
  } fetch_state_e;

  fetch_state_e state_r;
  fetch_state_e state_s;
  logic [31:0]  buf_instr_r;
  logic [31:0]  buf_pc_r;
  logic         buf_load_s;
  logic         cand_valid_s;
  logic [31:0]  cand_instr_s;
  logic [31:0]  cand_pc_s;
  logic [31:0]  pc_next_s;

  assign bus.imem_addr = PCF;
  assign bus.imem_req  = ~reset & (state_r != BUFFERED);
  assign FetchBusy     = bus.imem_req & ~bus.imem_ack;

  // Next-state, candidate selection and next-PC; a redirect always wins.
  always_comb begin
    state_s      = state_r;
    buf_load_s   = 1'b0;
    cand_valid_s = 1'b0;
    cand_instr_s = buf_instr_r;
    cand_pc_s    = buf_pc_r;
    pc_next_s    = PCF;
    case (state_r)
      FETCH: begin
        if (PCSrcE) begin
          // An ack arriving with the redirect is simply discarded; only a
          // still-outstanding request needs its late ack dropped.
          if (bus.imem_ack) begin
            state_s = FETCH;
          end else begin
            state_s = DROP;
          end
        end else if (bus.imem_ack) begin
          if (StallF) begin
            buf_load_s = 1'b1;
            state_s    = BUFFERED;
          end else begin
            cand_valid_s = 1'b1;
            cand_instr_s = bus.imem_rdata;
            cand_pc_s    = PCF;
            state_s      = FETCH;
          end
        end else begin
          state_s = FETCH;
        end
      end
      BUFFERED: begin
        if (PCSrcE) begin
          state_s = FETCH;
        end else if (!StallF) begin
          cand_valid_s = 1'b1;
          state_s      = FETCH;
        end else begin
          state_s = BUFFERED;
        end
      end
      DROP: begin
        if (bus.imem_ack) begin
          state_s = FETCH;
        end else begin
          state_s = DROP;
        end
      end
      default: begin
        state_s = FETCH;
      end
    endcase
    if (PCSrcE) begin
      pc_next_s = PCTargetE;
    end else if (cand_valid_s) begin
      pc_next_s = PCF + 32'd4;
    end else begin
      pc_next_s = PCF;
    end
  end

  // FSM state, PC and one-entry stall buffer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= FETCH;
      PCF         <= RESET_PC;
      buf_instr_r <= NOP_INSTR;
      buf_pc_r    <= 32'h0000_0000;
    end else begin
      state_r <= state_s;
      PCF     <= pc_next_s;
      if (buf_load_s) begin
        buf_instr_r <= bus.imem_rdata;
        buf_pc_r    <= PCF;
      end else begin
        buf_instr_r <= buf_instr_r;
        buf_pc_r    <= buf_pc_r;
      end
    end
  end

  // IF/ID register: flush beats stall beats load; no candidate loads a bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      InstrD   <= NOP_INSTR;
      PCD      <= 32'h0000_0000;
      PCPlus4D <= 32'h0000_0000;
      ValidD   <= 1'b0;
    end else if (FlushD) begin
      InstrD   <= NOP_INSTR;
      PCD      <= 32'h0000_0000;
      PCPlus4D <= 32'h0000_0000;
      ValidD   <= 1'b0;
    end else if (StallD) begin
      InstrD   <= InstrD;
      PCD      <= PCD;
      PCPlus4D <= PCPlus4D;
      ValidD   <= ValidD;
    end else if (cand_valid_s) begin
      InstrD   <= cand_instr_s;
      PCD      <= cand_pc_s;
      PCPlus4D <= cand_pc_s + 32'd4;
      ValidD   <= 1'b1;
    end else begin
      InstrD   <= NOP_INSTR;
      PCD      <= 32'h0000_0000;
      PCPlus4D <= 32'h0000_0000;
      ValidD   <= 1'b0;
    end
  end

`ifdef FETCH_PERF_EN
  // Count real loads and memory-wait bubbles into IF/ID.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetched <= 32'h0000_0000;
      perf_bubbles <= 32'h0000_0000;
    end else if (!StallD && !FlushD) begin
      if (cand_valid_s) begin
        perf_fetched <= perf_fetched + 32'd1;
        perf_bubbles <= perf_bubbles;
      end else begin
        perf_fetched <= perf_fetched;
        perf_bubbles <= perf_bubbles + 32'd1;
      end
    end else begin
      perf_fetched <= perf_fetched;
      perf_bubbles <= perf_bubbles;
    end
  end
`endif

  fetch_decode_stage_checker #(
    .NOP_INSTR (NOP_INSTR)
  ) u_checker (
    .clk        (clk),
    .reset      (reset),
    .state      (state_r),
    .req        (bus.imem_req),
    .ack        (bus.imem_ack),
    .addr       (bus.imem_addr),
    .pcf        (PCF),
    .fetch_busy (FetchBusy),
    .valid_d    (ValidD),
    .instr_d    (InstrD)
  );

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Scoreboard bench for fetch_decode_stage: expected IF/ID contents are queued as
// the bench schedules fetches and popped whenever ValidD shows a real instruction.
module tb_fetch_decode_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        StallF = 1'b0;
  logic        StallD = 1'b0;
  logic        FlushD = 1'b0;
  logic        PCSrcE = 1'b0;
  logic [31:0] PCTargetE = 32'h0000_0000;
  logic [31:0] PCF, InstrD, PCD, PCPlus4D;
  logic        ValidD, FetchBusy;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_bubbles;
`endif
  logic        ack_en = 1'b0;
  logic        ovr_en = 1'b0;
  logic [31:0] ovr_data = 32'h0000_0000;

  int   checks = 0;
  int   failures = 0;
  exp_t sb_q[$];
  exp_t exp_e;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {16'hC0DE ^ a[31:16], a[15:0]};
  endfunction

  fetch_decode_stage_if bus();

  // Memory model: acks whenever enabled; ovr_en presents stale data for a late ack.
  assign bus.imem_ack   = ack_en & bus.imem_req;
  assign bus.imem_rdata = ovr_en ? ovr_data : mem_word(bus.imem_addr);

  always #5 clk = ~clk;

  fetch_decode_stage dut (
    .clk       (clk),
    .reset     (reset),
    .StallF    (StallF),
    .StallD    (StallD),
    .FlushD    (FlushD),
    .PCSrcE    (PCSrcE),
    .PCTargetE (PCTargetE),
    .bus       (bus),
    .PCF       (PCF),
    .InstrD    (InstrD),
    .PCD       (PCD),
    .PCPlus4D  (PCPlus4D),
    .ValidD    (ValidD),
    .FetchBusy (FetchBusy)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_bubbles (perf_bubbles)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] pc);
    sb_q.push_back({pc, mem_word(pc)});
  endtask

  task automatic do_reset();
    reset = 1'b1; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0;
    PCTargetE = 32'h0000_0000; ack_en = 1'b0; ovr_en = 1'b0;
    sb_q.delete();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    checks++; if (PCF !== 32'h0000_0000) begin failures++; $display("FAIL rst_pcf actual=%h required=%h", PCF, 32'h0000_0000); end
    checks++; if (InstrD !== NOP) begin failures++; $display("FAIL rst_instr actual=%h required=%h", InstrD, NOP); end
    checks++; if (PCD !== 32'h0000_0000) begin failures++; $display("FAIL rst_pcd actual=%h required=%h", PCD, 32'h0000_0000); end
    checks++; if (PCPlus4D !== 32'h0000_0000) begin failures++; $display("FAIL rst_pcp4 actual=%h required=%h", PCPlus4D, 32'h0000_0000); end
    checks++; if (ValidD !== 1'b0) begin failures++; $display("FAIL rst_valid actual=%b required=0", ValidD); end
    checks++; if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL rst_req actual=%b required=0", bus.imem_req); end
  endtask

  task automatic test_zero_wait();
    do_reset();
    ack_en = 1'b1;
    for (int i = 0; i < 4; i++) push_exp(32'(i * 4));
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (ValidD !== 1'b1 || sb_q.size() == 0) begin
        failures++; $display("FAIL zw_valid cyc=%0d ValidD=%b required=1", i, ValidD);
      end else begin
        exp_e = sb_q.pop_front();
        checks++;
        if (PCD !== exp_e.pc || InstrD !== exp_e.instr || PCPlus4D !== exp_e.pc + 32'd4) begin
          failures++; $display("FAIL zw_load cyc=%0d PCD=%h InstrD=%h PCPlus4D=%h required %h %h %h",
                               i, PCD, InstrD, PCPlus4D, exp_e.pc, exp_e.instr, exp_e.pc + 32'd4);
        end
      end
    end
    checks++; if (PCF !== 32'h0000_0010) begin failures++; $display("FAIL zw_pcf actual=%h required=%h", PCF, 32'h0000_0010); end
`ifdef FETCH_PERF_EN
    checks++; if (perf_fetched !== 32'd4 || perf_bubbles !== 32'd0) begin failures++; $display("FAIL zw_perf fetched=%0d bubbles=%0d required 4 0", perf_fetched, perf_bubbles); end
`endif
  endtask

  task automatic test_mem_wait();
    do_reset();
    push_exp(32'h0); push_exp(32'h4); push_exp(32'h8);
    for (int i = 0; i < 5; i++) begin
      ack_en = (i == 2 || i == 3) ? 1'b0 : 1'b1;
      #1;
      if (i == 2 || i == 3) begin
        checks++; if (FetchBusy !== 1'b1) begin failures++; $display("FAIL wait_busy cyc=%0d actual=%b required=1", i, FetchBusy); end
        checks++; if (PCF !== 32'h0000_0008) begin failures++; $display("FAIL wait_pcf cyc=%0d actual=%h required=%h", i, PCF, 32'h0000_0008); end
      end
      tick();
      if (i == 2 || i == 3) begin
        checks++;
        if (InstrD !== NOP || ValidD !== 1'b0) begin failures++; $display("FAIL wait_bubble cyc=%0d InstrD=%h ValidD=%b required %h 0", i, InstrD, ValidD, NOP); end
      end else begin
        checks++;
        if (ValidD !== 1'b1 || sb_q.size() == 0) begin
          failures++; $display("FAIL wait_valid cyc=%0d ValidD=%b required=1", i, ValidD);
        end else begin
          exp_e = sb_q.pop_front();
          checks++;
          if (PCD !== exp_e.pc || InstrD !== exp_e.instr) begin
            failures++; $display("FAIL wait_load cyc=%0d PCD=%h InstrD=%h required %h %h", i, PCD, InstrD, exp_e.pc, exp_e.instr);
          end
        end
      end
    end
    checks++; if (sb_q.size() != 0) begin failures++; $display("FAIL wait_drain left=%0d required=0", sb_q.size()); end
`ifdef FETCH_PERF_EN
    checks++; if (perf_fetched !== 32'd3 || perf_bubbles !== 32'd2) begin failures++; $display("FAIL wait_perf fetched=%0d bubbles=%0d required 3 2", perf_fetched, perf_bubbles); end
`endif
  endtask

  task automatic test_stall_buffer();
    do_reset();
    ack_en = 1'b1;
    push_exp(32'h0); push_exp(32'h4); push_exp(32'h8); push_exp(32'hC); push_exp(32'h10);
    for (int i = 0; i < 8; i++) begin
      StallF = (i >= 3 && i <= 5);
      StallD = (i >= 3 && i <= 5);
      #1;
      if (i >= 4 && i <= 6) begin
        checks++; if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL stall_req cyc=%0d actual=%b required=0", i, bus.imem_req); end
      end
      tick();
      if (i >= 3 && i <= 5) begin
        checks++;
        if (PCD !== 32'h8 || InstrD !== mem_word(32'h8) || ValidD !== 1'b1 || PCF !== 32'hC) begin
          failures++; $display("FAIL stall_hold cyc=%0d PCD=%h InstrD=%h ValidD=%b PCF=%h required %h %h 1 %h",
                               i, PCD, InstrD, ValidD, PCF, 32'h8, mem_word(32'h8), 32'hC);
        end
      end else begin
        checks++;
        if (ValidD !== 1'b1 || sb_q.size() == 0) begin
          failures++; $display("FAIL stall_valid cyc=%0d ValidD=%b required=1", i, ValidD);
        end else begin
          exp_e = sb_q.pop_front();
          checks++;
          if (PCD !== exp_e.pc || InstrD !== exp_e.instr) begin
            failures++; $display("FAIL stall_load cyc=%0d PCD=%h InstrD=%h required %h %h", i, PCD, InstrD, exp_e.pc, exp_e.instr);
          end
        end
      end
    end
  endtask

  task automatic test_redirect_drop();
    do_reset();
    push_exp(32'h0); push_exp(32'h4); push_exp(32'h8); push_exp(32'hC); push_exp(32'h40);
    for (int i = 0; i < 8; i++) begin
      ack_en    = !(i == 4 || i == 5);
      PCSrcE    = (i == 4);
      PCTargetE = 32'h0000_0040;
      ovr_en    = (i == 6);
      ovr_data  = mem_word(32'h10);
      #1;
      if (i == 5) begin
        checks++; if (bus.imem_req !== 1'b1 || FetchBusy !== 1'b1) begin failures++; $display("FAIL drop_req req=%b busy=%b required 1 1", bus.imem_req, FetchBusy); end
      end
      if (i == 7) begin
        checks++; if (bus.imem_addr !== 32'h40) begin failures++; $display("FAIL drop_addr actual=%h required=%h", bus.imem_addr, 32'h40); end
      end
      tick();
      if (i >= 4 && i <= 6) begin
        checks++;
        if (InstrD !== NOP || ValidD !== 1'b0 || PCF !== 32'h40) begin
          failures++; $display("FAIL drop_bubble cyc=%0d InstrD=%h ValidD=%b PCF=%h required %h 0 %h", i, InstrD, ValidD, PCF, NOP, 32'h40);
        end
      end else begin
        checks++;
        if (ValidD !== 1'b1 || sb_q.size() == 0) begin
          failures++; $display("FAIL drop_valid cyc=%0d ValidD=%b required=1", i, ValidD);
        end else begin
          exp_e = sb_q.pop_front();
          checks++;
          if (PCD !== exp_e.pc || InstrD !== exp_e.instr) begin
            failures++; $display("FAIL drop_load cyc=%0d PCD=%h InstrD=%h required %h %h", i, PCD, InstrD, exp_e.pc, exp_e.instr);
          end
        end
      end
    end
    ovr_en = 1'b0;
  endtask

  task automatic test_flush_redirect_ack();
    do_reset();
    ack_en = 1'b1;
    push_exp(32'h0); push_exp(32'h4); push_exp(32'h80);
    for (int i = 0; i < 5; i++) begin
      FlushD    = (i == 2);
      PCSrcE    = (i == 3);
      PCTargetE = 32'h0000_0080;
      tick();
      if (i == 2) begin
        checks++;
        if (InstrD !== NOP || ValidD !== 1'b0 || PCF !== 32'hC) begin
          failures++; $display("FAIL flush cyc=%0d InstrD=%h ValidD=%b PCF=%h required %h 0 %h", i, InstrD, ValidD, PCF, NOP, 32'hC);
        end
      end else if (i == 3) begin
        checks++;
        if (InstrD !== NOP || ValidD !== 1'b0 || PCF !== 32'h80) begin
          failures++; $display("FAIL redir_ack cyc=%0d InstrD=%h ValidD=%b PCF=%h required %h 0 %h", i, InstrD, ValidD, PCF, NOP, 32'h80);
        end
      end else begin
        checks++;
        if (ValidD !== 1'b1 || sb_q.size() == 0) begin
          failures++; $display("FAIL flush_valid cyc=%0d ValidD=%b required=1", i, ValidD);
        end else begin
          exp_e = sb_q.pop_front();
          checks++;
          if (PCD !== exp_e.pc || InstrD !== exp_e.instr) begin
            failures++; $display("FAIL flush_load cyc=%0d PCD=%h InstrD=%h required %h %h", i, PCD, InstrD, exp_e.pc, exp_e.instr);
          end
        end
      end
    end
    FlushD = 1'b0; PCSrcE = 1'b0;
  endtask

  task automatic test_pc_wrap();
    do_reset();
    ack_en = 1'b1;
    PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFC;
    tick();
    checks++; if (PCF !== 32'hFFFF_FFFC || ValidD !== 1'b0) begin failures++; $display("FAIL wrap_redir PCF=%h ValidD=%b required %h 0", PCF, ValidD, 32'hFFFF_FFFC); end
    PCSrcE = 1'b0;
    push_exp(32'hFFFF_FFFC); push_exp(32'h0);
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (ValidD !== 1'b1 || sb_q.size() == 0) begin
        failures++; $display("FAIL wrap_valid cyc=%0d ValidD=%b required=1", i, ValidD);
      end else begin
        exp_e = sb_q.pop_front();
        checks++;
        if (PCD !== exp_e.pc || InstrD !== exp_e.instr || PCPlus4D !== exp_e.pc + 32'd4) begin
          failures++; $display("FAIL wrap_load cyc=%0d PCD=%h InstrD=%h PCPlus4D=%h required %h %h %h",
                               i, PCD, InstrD, PCPlus4D, exp_e.pc, exp_e.instr, exp_e.pc + 32'd4);
        end
      end
    end
    checks++; if (PCF !== 32'h4) begin failures++; $display("FAIL wrap_pcf actual=%h required=%h", PCF, 32'h4); end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    ack_en = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    ack_en = 1'b0;
    tick();
    checks++; if (PCF !== 32'h20 || FetchBusy !== 1'b1) begin failures++; $display("FAIL mid_pre PCF=%h busy=%b required %h 1", PCF, FetchBusy, 32'h20); end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (PCF !== 32'h0 || InstrD !== NOP || PCD !== 32'h0 || PCPlus4D !== 32'h0 || ValidD !== 1'b0 || bus.imem_req !== 1'b0) begin
      failures++; $display("FAIL mid_async PCF=%h InstrD=%h PCD=%h PCPlus4D=%h ValidD=%b req=%b required 0 %h 0 0 0 0",
                           PCF, InstrD, PCD, PCPlus4D, ValidD, bus.imem_req, NOP);
    end
    tick();
    reset = 1'b0;
    ack_en = 1'b1;
    #1;
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin failures++; $display("FAIL mid_rereq req=%b addr=%h required 1 %h", bus.imem_req, bus.imem_addr, 32'h0); end
    tick();
    checks++; if (ValidD !== 1'b1 || PCD !== 32'h0 || InstrD !== mem_word(32'h0)) begin failures++; $display("FAIL mid_first ValidD=%b PCD=%h InstrD=%h required 1 0 %h", ValidD, PCD, InstrD, mem_word(32'h0)); end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_mem_wait();
    test_stall_buffer();
    test_redirect_drop();
    test_flush_redirect_ack();
    test_pc_wrap();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end
endmodule
